// File: rtl/ysyx_22040895_pkg.sv
// Shared definitions for the ysyx_22040895 memory arbiter: FSM encoding,
// timeout default and watchdog counter width.
package ysyx_22040895_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned WDOG_W      = 8;

endpackage

// File: rtl/ysyx_22040895_wdog.sv
// Transaction watchdog: saturating cycle counter cleared on accept, counting
// while a transaction is in flight; flags expiry at count == TIMEOUT.
module ysyx_22040895_wdog
    import ysyx_22040895_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/ysyx_22040895_memarb.sv
// Two-port (fetch / load-store) round-robin arbiter onto a single memory
// channel with one outstanding transaction and a completion watchdog.
module ysyx_22040895_memarb
    import ysyx_22040895_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid_i,
    output logic                if_req_ready_o,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_rsp_valid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,

    input  logic                ls_req_valid_i,
    output logic                ls_req_ready_o,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic                ls_we_i,
    input  logic [DATA_W/8-1:0] ls_wstrb_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    output logic                ls_rsp_valid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_err_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    output logic [DATA_W-1:0]   mem_wdata_o,

    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                busy_o
);

    state_t state, state_nxt;

    logic                last_ls;
    logic                owner_ls;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                if_rsp_q, ls_rsp_q, err_q;
    logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

    logic sel_if, sel_ls;
    logic accept, active, timeout, mem_done, finish, rsp_pulse;
    logic [DATA_W-1:0] rsp_data;

    // Round-robin: on conflict, serve whoever was not served last.
    assign sel_ls    = ls_req_valid_i && (!if_req_valid_i || !last_ls);
    assign sel_if    = if_req_valid_i && !sel_ls;
    assign rsp_pulse = if_rsp_q || ls_rsp_q;

    assign accept    = (if_req_valid_i && if_req_ready_o) || (ls_req_valid_i && ls_req_ready_o);
    assign active    = (state != IDLE);
    assign mem_done  = (state == RESP) && mem_rsp_valid_i;
    assign finish    = mem_done || timeout;
    assign rsp_data  = (mem_done && !we_q) ? mem_rdata_i : '0;

    ysyx_22040895_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (active),
        .expired(timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ: begin
                if (timeout)              state_nxt = IDLE;
                else if (mem_req_ready_i) state_nxt = RESP;
            end
            RESP: if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are withheld in the response-pulse cycle so a new accept
    // never overlaps the previous completion.
    always_comb begin
        if_req_ready_o  = 1'b0;
        ls_req_ready_o  = 1'b0;
        mem_req_valid_o = 1'b0;
        busy_o          = 1'b1;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (!rsp_pulse) begin
                    if_req_ready_o = sel_if;
                    ls_req_ready_o = sel_ls;
                end
            end
            REQ:     mem_req_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_ls    <= 1'b0;
            owner_ls   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            if_rsp_q   <= 1'b0;
            ls_rsp_q   <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if_rsp_q <= 1'b0;
            ls_rsp_q <= 1'b0;
            if (accept) begin
                owner_ls <= ls_req_ready_o;
                last_ls  <= ls_req_ready_o;
                addr_q   <= ls_req_ready_o ? ls_addr_i : if_addr_i;
                we_q     <= ls_req_ready_o && ls_we_i;
                wstrb_q  <= ls_req_ready_o ? ls_wstrb_i : '0;
                wdata_q  <= ls_req_ready_o ? ls_wdata_i : '0;
            end
            if (finish) begin
                err_q <= !mem_done;
                if (owner_ls) begin
                    ls_rsp_q   <= 1'b1;
                    ls_rdata_q <= rsp_data;
                end else begin
                    if_rsp_q   <= 1'b1;
                    if_rdata_q <= rsp_data;
                end
            end
        end
    end

    assign if_rsp_valid_o = if_rsp_q;
    assign if_rdata_o     = if_rdata_q;
    assign if_err_o       = if_rsp_q && err_q;
    assign ls_rsp_valid_o = ls_rsp_q;
    assign ls_rdata_o     = ls_rdata_q;
    assign ls_err_o       = ls_rsp_q && err_q;

    assign mem_addr_o     = addr_q;
    assign mem_we_o       = we_q;
    assign mem_wstrb_o    = wstrb_q;
    assign mem_wdata_o    = wdata_q;

endmodule

// File: doc/ysyx_22040895_memarb.md
YSYX_22040895_MEMARB -- requirements
Module: ysyx_22040895_memarb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles a granted transaction may wait for completion.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port if_req_valid_i  in  1  instruction-fetch read request.
REQ-007 SHALL have port if_req_ready_o  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_addr_i  in  ADDR_W  fetch address.
REQ-009 SHALL have port if_rsp_valid_o  out  1  one-cycle fetch response strobe.
REQ-010 SHALL have port if_rdata_o  out  DATA_W  fetch read data.
REQ-011 SHALL have port if_err_o  out  1  fetch timed out; qualified by if_rsp_valid_o.
REQ-012 SHALL have port ls_req_valid_i  in  1  load/store request.
REQ-013 SHALL have port ls_req_ready_o  out  1  load/store request accepted this cycle.
REQ-014 SHALL have ports ls_addr_i  in  ADDR_W, ls_we_i  in  1, ls_wstrb_i  in  DATA_W/8, ls_wdata_i  in  DATA_W: load/store address, write enable, byte strobe, write data.
REQ-015 SHALL have ports ls_rsp_valid_o  out  1, ls_rdata_o  out  DATA_W, ls_err_o  out  1: load/store response, mirroring the fetch response ports.
REQ-016 SHALL have ports mem_req_valid_o  out  1, mem_req_ready_i  in  1, mem_addr_o  out  ADDR_W, mem_we_o  out  1, mem_wstrb_o  out  DATA_W/8, mem_wdata_o  out  DATA_W: shared memory request channel.
REQ-017 SHALL have ports mem_rsp_valid_i  in  1, mem_rdata_i  in  DATA_W: shared memory response channel.
REQ-018 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, RESP with exactly one outstanding transaction.
REQ-020 SHALL, in IDLE, assert at most one ready_o, combinationally, for the selected requester; handshake = valid & ready.
REQ-021 SHALL select the sole valid requester; when both are valid, the one not served last (round-robin flag last_ls, updated on each accept).
REQ-022 SHALL, on accept, latch addr/we/wstrb/wdata and the grant owner, then move to REQ; fetch requests latch we=0, wstrb=0, wdata=0.
REQ-023 SHALL, in REQ, hold mem_req_valid_o=1 with latched fields stable until mem_req_ready_i=1, then move to RESP.
REQ-024 SHALL, in RESP, on mem_rsp_valid_i=1, register mem_rdata_i into the owner's rdata_o, pulse its rsp_valid_o for exactly one cycle with err_o=0, and return to IDLE.
REQ-025 SHALL ignore mem_rsp_valid_i in IDLE and REQ.
REQ-026 SHALL return rdata 0 for write responses.
REQ-027 SHALL count cycles spent in REQ+RESP with an 8-bit saturating counter cleared on accept; at count == TIMEOUT it SHALL pulse the owner's rsp_valid_o with err_o=1 and rdata 0, drop mem_req_valid_o, and return to IDLE.
REQ-028 SHALL give minimum latency 3 cycles: accept at T, memory accepts at T+1, response arrives at T+2, rsp_valid_o at T+3.
REQ-029 SHALL NOT accept a new request in the cycle a response pulses; the next accept is at the earliest in the following IDLE cycle.
REQ-030 SHALL drive the non-owner's rsp_valid_o 0 throughout.

Reset
REQ-031 SHALL, when rst=0 at a clock edge, enter IDLE, set last_ls=0 (first conflict grants LS), clear counter, and drive all outputs to 0.
REQ-032 SHALL, on reset mid-transaction, abandon the transaction without issuing any response.

Structure
REQ-033 SHALL place the state enum and the TIMEOUT default in the shared ysyx_22040895 define header.
REQ-034 SHALL keep the arbitration and FSM in one module; the timeout counter SHALL be sub-module ysyx_22040895_wdog.

Verification
REQ-035 IF-only read at 0x8000_0000, mem_req_ready_i=1 immediately, response 0xDEAD_BEEF one cycle later -> if_rsp_valid_o at T+3, if_rdata_o=0xDEAD_BEEF, if_err_o=0.
REQ-036 IF and LS both valid after reset -> LS granted first; the next IF+LS conflict is granted to IF.
REQ-037 LS write, addr 0x8000_0010, wstrb 0x0F, mem_req_ready_i held 0 for 5 cycles -> mem fields stable for all 5 cycles; ls_rsp_valid_o with rdata 0.
REQ-038 Granted read with no mem_rsp_valid_i -> err_o=1 and rsp_valid_o after TIMEOUT=255 cycles; busy_o=0 on the next cycle.
REQ-039 rst=0 asserted while in RESP, then mem_rsp_valid_i=1 -> no rsp_valid_o; state IDLE; all outputs 0.
REQ-040 mem_rsp_valid_i=1 pulsed in IDLE -> no rsp_valid_o and no state change.
